// File: rtl/div_pkg.sv
// Shared constants for the EX-stage divider: bus width, reset level, FSM encodings
// and handshake levels.
package div_pkg;

  localparam int          RegBus     = 32;
  localparam logic [31:0] ZeroWord   = 32'h0000_0000;
  localparam logic        RstEnable  = 1'b1;
  localparam logic        RstEnableN = 1'b0;  // the divider's reset is active-low

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

endpackage

// File: rtl/div.sv
// Multi-cycle restoring divider for DIV/DIVU: 32 iterations, one quotient bit per edge.
// result_o = {remainder, quotient}, registered and held while start_i stays high.
module div
  import div_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  div_state_e  state, nxt_state;
  logic [5:0]  cnt;
  logic [64:0] work;      // [63:32] partial remainder, [31:0] dividend bits / quotient
  logic [31:0] divisor;
  logic        neg_q, neg_r;

  logic        accept;
  logic [31:0] op1_mag, op2_mag;
  logic [64:0] sh, step;
  logic [32:0] trial;
  logic        borrow;
  logic [31:0] q_fix, r_fix;

  assign accept  = (start_i == DivStart) && !annul_i;
  assign op1_mag = (signed_div_i && opdata1_i[31]) ? neg32(opdata1_i) : opdata1_i;
  assign op2_mag = (signed_div_i && opdata2_i[31]) ? neg32(opdata2_i) : opdata2_i;

  // sh[64] set means the shifted remainder already exceeds any 32-bit divisor
  assign sh     = {work[63:0], 1'b0};
  assign trial  = {1'b0, sh[63:32]} - {1'b0, divisor};
  assign borrow = trial[32] & ~sh[64];
  assign step   = borrow ? sh : {1'b0, trial[31:0], sh[31:1], 1'b1};
  assign q_fix  = neg_q ? neg32(step[31:0])  : step[31:0];
  assign r_fix  = neg_r ? neg32(step[63:32]) : step[63:32];

  always_comb begin
    nxt_state = state;
    case (state)
      DivFree:   if (accept) nxt_state = (opdata2_i == ZeroWord) ? DivByZero : DivOn;
      DivByZero: nxt_state = annul_i ? DivFree : DivEnd;
      DivOn: begin
        if (annul_i)          nxt_state = DivFree;
        else if (cnt == 6'd31) nxt_state = DivEnd;
      end
      DivEnd:    if (!accept) nxt_state = DivFree;
      default:   nxt_state = DivFree;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnableN) begin
      state    <= DivFree;
      cnt      <= '0;
      work     <= '0;
      divisor  <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= '0;
      ready_o  <= DivResultNotReady;
    end else begin
      state <= nxt_state;
      case (state)
        DivFree: if (accept) begin
          work    <= {33'd0, op1_mag};
          divisor <= op2_mag;
          neg_q   <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
          neg_r   <= signed_div_i & opdata1_i[31];
          cnt     <= '0;
        end
        DivByZero: if (!annul_i) begin
          result_o <= '0;
          ready_o  <= DivResultReady;
        end
        DivOn: if (annul_i) begin
          cnt <= '0;
        end else begin
          work <= step;
          cnt  <= cnt + 6'd1;
          if (cnt == 6'd31) begin
            result_o <= {r_fix, q_fix};
            ready_o  <= DivResultReady;
          end
        end
        DivEnd: if (!accept) begin
          result_o <= '0;
          ready_o  <= DivResultNotReady;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/div.md
# div

Multi-cycle 32-bit integer divider for the EX stage of the MIPS32 pipeline. It produces the HI/LO pair for DIV and DIVU: remainder to HI, quotient to LO. EX forwards that pair, with its HI/LO write enable, into the EX/MEM latch. EX holds `start_i` high and stalls the pipeline until `ready_o` rises.

## Interface
- No parameters; data width is fixed at 32 (`RegBus`).
- Clock and reset: one clock; reset is synchronous and active-low.
- `clk` input 1 — pipeline clock; all state changes on rising edge.
- `rst` input 1 — synchronous, active-low reset.
- `signed_div_i` input 1 — 1 = DIV (two's complement), 0 = DIVU.
- `opdata1_i` input 32 — dividend; sampled at start acceptance only.
- `opdata2_i` input 32 — divisor; sampled at start acceptance only.
- `start_i` input 1 — request; held high by EX until the result is consumed.
- `annul_i` input 1 — abort the in-flight division (branch flush or exception).
- `result_o` output 64 — {remainder[63:32], quotient[31:0]}.
- `ready_o` output 1 — `result_o` is valid.

## Operation
- Reset: state `DivFree`, `result_o` = 0, `ready_o` = 0, iteration count = 0, working registers = 0.
- **DivFree**
  - If `start_i`=1 and `annul_i`=0: latch the operands.
  - If the divisor is 0, go to `DivByZero`. Otherwise go to `DivOn` with count = 0.
  - In signed mode, negative operands are replaced by their two's-complement magnitudes before latching.
- **DivByZero**: next edge goes to `DivEnd` with quotient = 0 and remainder = 0.
- **DivOn**
  - Restoring division, one quotient bit per edge, MSB first, using a 65-bit partial remainder/dividend shift register.
  - Each edge: shift left 1, compute a 33-bit trial subtract of the divisor from the upper half. If there is no borrow, keep the difference and set the new LSB to 1; otherwise keep the shifted value and set the LSB to 0.
  - After the 32nd iteration go to `DivEnd`.
- **DivEnd**
  - Sign fix-up in signed mode: negate the quotient if the operand signs differed; negate the remainder if the dividend was negative. The fix-up is applied before the value appears on `result_o`.
  - `ready_o`=1 and `result_o` holds steady for as long as `start_i`=1.
  - When `start_i`=0, next edge goes to `DivFree`, `ready_o` → 0, `result_o` → 0.
- `annul_i`=1 in `DivOn` or `DivByZero`: next edge goes to `DivFree`, `ready_o` stays 0, `result_o` = 0, and no result is produced.
- `annul_i` in `DivEnd`: treated like `start_i`=0.
- Signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0. This is a defined result and no trap is raised.
- `start_i` dropped while in `DivOn` without `annul_i`: the division completes and `DivEnd` exits on the following edge.
- Operand changes after acceptance are ignored.

## Timing
- Acceptance edge = edge A, where `DivFree` sees `start_i`=1.
- Normal division: `ready_o`=1 from the cycle after edge A+32, i.e. 33 cycles after A.
- Divide by zero: `ready_o`=1 in the cycle after edge A+1.
- `ready_o` is registered. There is no combinational path from any input to any output.
- Back-to-back divisions: at least one `DivFree` cycle between results, since `start_i` must drop to leave `DivEnd`.
- `rst` low at any edge overrides everything, including mid-division; the block returns to the reset values in the next cycle.

## Structure
- The shared defines file (alongside `RstEnable`, `ZeroWord`, `RegBus`) holds:
  - state encodings `DivFree`, `DivByZero`, `DivOn`, `DivEnd` (2 bits);
  - `DivResultReady` and `DivResultNotReady`;
  - `DivStart` and `DivStop`.
  - Because this block's reset is active-low, the defines also include a matching active-low reset-enable constant.
- No sub-module: a single FSM plus the datapath, with the 33-bit trial subtract inline.
- EX concatenation: `result_o[63:32]` → `ex_hi`, `result_o[31:0]` → `ex_lo`, and `ex_whilo`=1 only in the cycle where `ready_o`=1.

## Test plan
- DIVU 100 / 7 → `ready_o` 33 cycles after acceptance; `result_o` = {0x00000002, 0x0000000E}.
- DIV −7 (0xFFFFFFF9) / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. DIV 7 / −2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- DIV and DIVU 0x12345678 / 0 → `ready_o` 2 cycles after acceptance; `result_o` = 0.
- DIV 0x80000000 / 0xFFFFFFFF → {0, 0x80000000}. DIVU 0xFFFFFFFF / 1 → {0, 0xFFFFFFFF}.
- Assert `annul_i` at iteration 10 → `DivFree` next cycle and `ready_o` never rises. A new start on the following cycle (50 / 5) gives {0, 10} with full latency.
- Pull `rst` low at iteration 20 → all outputs 0 the next cycle. Hold `start_i` high 5 cycles past `ready_o` → result stays stable; dropping `start_i` clears `ready_o` one cycle later.
